// File: rtl/ifmap_row_scheduler.sv
// ifmap_row_scheduler
// Sequences IFMAP row reads for the partial-sum PEs. After start it issues
// every PE's first row, then round-robin arbitrates PE row requests, walking
// each PE's row pointer k, k+NUM_PE, k+2*NUM_PE, ... Each grant produces one
// read command held in a single-entry output register. Two timesteps are
// processed in turn, then the block parks in DONE.
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   start              pulse, leaves IDLE
//   req[NUM_PE]        per-PE next-row request pulses
//   ts_advance         pulse, finishes the current timestep (TS_WAIT only)
//   rd_valid/rd_ready  read command handshake
//   rd_addr            bit address of the row start
//   rd_row, rd_ts      row index and timestep of the command
//   rd_dest            NoC ID of the destination PE
//   rd_last            final row for that PE in this timestep
//   req_drop           pulse, a request came from an exhausted PE
//   done               high once both timesteps are complete
module ifmap_row_scheduler #(
    parameter int unsigned IFMAP_SIZE = 25,
    parameter int unsigned NUM_PE     = 5,
    parameter int unsigned PE_BASE_ID = 5,
    parameter int unsigned ROW_W      = 5,
    parameter int unsigned ADDR_W     = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [NUM_PE-1:0] req,
    input  logic              ts_advance,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ROW_W-1:0]  rd_row,
    output logic              rd_ts,
    output logic [3:0]        rd_dest,
    output logic              rd_last,
    output logic              req_drop,
    output logic              done
);

    localparam int unsigned IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    // One spare bit so the pointer can step past IFMAP_SIZE without wrapping.
    localparam int unsigned PTR_W = ROW_W + 1;

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StServe,
        StTsWait,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic              ts_q, ts_d;
    logic [PTR_W-1:0]  ptr_q [NUM_PE];
    logic [PTR_W-1:0]  ptr_d [NUM_PE];
    logic [NUM_PE-1:0] pending_q, pending_d;
    logic [IDX_W-1:0]  last_grant_q, last_grant_d;
    logic [IDX_W-1:0]  init_idx_q, init_idx_d;
    logic              req_drop_q, req_drop_d;

    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ROW_W-1:0]  row_q;
    logic              cmd_ts_q;
    logic [3:0]        dest_q;
    logic              last_q;

    logic [NUM_PE-1:0] exhausted;
    logic              load_ok;
    logic              grant_found;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W-1:0]  cand_idx;
    logic              issue;
    logic [IDX_W-1:0]  issue_idx;
    logic [PTR_W-1:0]  issue_ptr;
    logic [ADDR_W-1:0] issue_addr;
    logic              issue_last;

    always_comb begin
        for (int k = 0; k < NUM_PE; k++) begin
            exhausted[k] = 32'(ptr_q[k]) >= IFMAP_SIZE;
        end
    end

    // Register is free when empty or being accepted this cycle.
    assign load_ok = !valid_q || rd_ready;

    // Round-robin search starting just after the last granted PE.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int unsigned i = 1; i <= NUM_PE; i++) begin
            cand_idx = IDX_W'((32'(last_grant_q) + i) % NUM_PE);
            if (!grant_found && pending_q[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ts_d         = ts_q;
        ptr_d        = ptr_q;
        pending_d    = pending_q;
        last_grant_d = last_grant_q;
        init_idx_d   = init_idx_q;
        req_drop_d   = 1'b0;
        issue        = 1'b0;
        issue_idx    = '0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StInit;
                    init_idx_d = '0;
                end
            end
            StInit: begin
                if (load_ok) begin
                    issue     = 1'b1;
                    issue_idx = init_idx_q;
                    if (32'(init_idx_q) == NUM_PE - 1) begin
                        state_d = StServe;
                    end else begin
                        init_idx_d = init_idx_q + IDX_W'(1);
                    end
                end
            end
            StServe: begin
                if (load_ok && grant_found) begin
                    issue                = 1'b1;
                    issue_idx            = grant_idx;
                    pending_d[grant_idx] = 1'b0;
                end else if ((&exhausted) && (pending_q == '0) && load_ok) begin
                    state_d = StTsWait;
                end
            end
            StTsWait: begin
                if (ts_advance) begin
                    if (!ts_q) begin
                        ts_d         = 1'b1;
                        pending_d    = '0;
                        last_grant_d = IDX_W'(NUM_PE - 1);
                        init_idx_d   = '0;
                        for (int k = 0; k < NUM_PE; k++) begin
                            ptr_d[k] = PTR_W'(k);
                        end
                        state_d = StInit;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
            end
            default: state_d = StIdle;
        endcase

        // Applied after the grant clear so a same-cycle request keeps pending set.
        if (state_q == StInit || state_q == StServe) begin
            pending_d  = pending_d | (req & ~exhausted);
            req_drop_d = |(req & exhausted);
        end

        if (issue) begin
            ptr_d[issue_idx] = ptr_q[issue_idx] + PTR_W'(NUM_PE);
            last_grant_d     = issue_idx;
        end
    end

    assign issue_ptr  = ptr_q[issue_idx];
    assign issue_addr = (ts_q ? ADDR_W'(IFMAP_SIZE * IFMAP_SIZE) : '0)
                      + ADDR_W'(issue_ptr) * ADDR_W'(IFMAP_SIZE);
    assign issue_last = (32'(issue_ptr) + NUM_PE) >= IFMAP_SIZE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            ts_q         <= 1'b0;
            pending_q    <= '0;
            last_grant_q <= IDX_W'(NUM_PE - 1);
            init_idx_q   <= '0;
            req_drop_q   <= 1'b0;
            for (int k = 0; k < NUM_PE; k++) begin
                ptr_q[k] <= PTR_W'(k);
            end
            valid_q  <= 1'b0;
            addr_q   <= '0;
            row_q    <= '0;
            cmd_ts_q <= 1'b0;
            dest_q   <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ts_q         <= ts_d;
            ptr_q        <= ptr_d;
            pending_q    <= pending_d;
            last_grant_q <= last_grant_d;
            init_idx_q   <= init_idx_d;
            req_drop_q   <= req_drop_d;
            if (issue) begin
                valid_q  <= 1'b1;
                addr_q   <= issue_addr;
                row_q    <= issue_ptr[ROW_W-1:0];
                cmd_ts_q <= ts_q;
                dest_q   <= 4'(PE_BASE_ID + 32'(issue_idx));
                last_q   <= issue_last;
            end else if (rd_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rd_valid = valid_q;
    assign rd_addr  = addr_q;
    assign rd_row   = row_q;
    assign rd_ts    = cmd_ts_q;
    assign rd_dest  = dest_q;
    assign rd_last  = last_q;
    assign req_drop = req_drop_q;
    assign done     = (state_q == StDone);

endmodule

// File: doc/ifmap_row_scheduler.md
Name: ifmap_row_scheduler

Overview:
- Clocked controller that sequences row reads from the IFMAP input memory on behalf of the five partial-sum PEs (IDs 5..9).
- After start, it issues each PE's first row. It then round-robin arbitrates PE row requests and advances a per-PE row pointer (rows k, k+5, k+10, ...).
- It emits one memory-read command per grant to the packetizer, then switches from timestep 1 to timestep 2 on command.

Parameters:
- IFMAP_SIZE, 25, rows per timestep and bits per row.
- NUM_PE, 5, number of requesting PEs; also the row stride.
- PE_BASE_ID, 5, NoC ID of PE index 0.
- ROW_W, 5, row index width.
- ADDR_W, 12, memory bit-address width.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  one-cycle pulse; inputs loaded and weights done; honoured only in IDLE.
- req  in  NUM_PE  per-PE one-cycle request pulses for the next row.
- ts_advance  in  1  pulse: current timestep finished; honoured only in TS_WAIT.
- rd_valid  out  1  read command valid.
- rd_ready  in  1  downstream accepts the command when rd_valid && rd_ready.
- rd_addr  out  ADDR_W  bit address of the row start, equal to ts*IFMAP_SIZE*IFMAP_SIZE + row*IFMAP_SIZE.
- rd_row  out  ROW_W  row index.
- rd_ts  out  1  0 = timestep 1, 1 = timestep 2.
- rd_dest  out  4  PE_BASE_ID + granted index.
- rd_last  out  1  row is the final row for that PE in this timestep (row + NUM_PE >= IFMAP_SIZE).
- req_drop  out  1  one-cycle pulse: a request arrived from an exhausted PE.
- done  out  1  high in DONE.

Behaviour:
- Reset values: state=IDLE, ts=0, ptr[k]=k, pending=0, all outputs 0. Reset mid-operation abandons any in-flight command; rd_valid drops asynchronously.
- Output register: one entry. The payload is held stable while rd_valid && !rd_ready. A new entry loads when the register is empty or is being accepted in the same cycle, giving one command per cycle at full throughput.
- IDLE: start moves to INIT. Other inputs are ignored, and req pulses are not latched.
- INIT: issues PE 0, 1, ..., NUM_PE-1 in order, one per load opportunity, each at row ptr[k]. After issuing the last PE, moves to SERVE. req pulses arriving during INIT are latched into pending.
- Pointer update on every issue: ptr[k] += NUM_PE. A PE is exhausted when ptr[k] >= IFMAP_SIZE.
- SERVE arbitration: a req pulse from a non-exhausted PE sets pending[k]. A duplicate while pending merges into the same request (no count).
  - Round-robin: search starts at (last_grant+1) mod NUM_PE. The grant clears pending and loads the output register on the same edge.
  - Latency: req sampled at edge t, then rd_valid asserts after edge t+1 if the output register is free.
- A req from an exhausted PE is dropped and pulses req_drop the next cycle; pending is unchanged.
- Simultaneous req[k] and grant of pending[k] in the same cycle: the set wins, so pending[k]=1 afterward.
- SERVE to TS_WAIT: all PEs exhausted, pending empty, and the output register empty or accepted this cycle.
- TS_WAIT on ts_advance:
  - If ts=0: set ts=1, reset ptr[k]=k, pending=0, last_grant=NUM_PE-1, go to INIT.
  - If ts=1: go to DONE.
- ts_advance outside TS_WAIT is ignored.
- DONE: done=1, no further commands, and req pulses are ignored. Only reset leaves DONE.
- Address arithmetic: computed at ADDR_W bits, no wrap. With the defaults, the maximum is 625+24*25=1225.

Test Plan:
- Reset, then start, with rd_ready held 1: five consecutive commands (dest,row,addr) = (5,0,0), (6,1,25), (7,2,50), (8,3,75), (9,4,100), all with rd_last=0.
- In SERVE, pulse req[2] alone: two cycles later one command with dest=7, row=7, addr=175. No other rd_valid.
- Pulse req=5'b11111 in one cycle after last_grant=4, with rd_ready=1: grants in order 0,1,2,3,4 on consecutive cycles at rows 5..9.
- Hold rd_ready=0 for 4 cycles with a command pending: rd_valid stays 1 with a constant payload. Set rd_ready=1: the next grant follows on the next cycle.
- Drive PE 0 through rows 0,5,10,15,20: row 20 has rd_last=1. A further req[0] gives req_drop=1 and no command.
- Exhaust all PEs, then pulse ts_advance: INIT reissues with rd_ts=1 and addrs 625,650,675,700,725. Exhaust again plus ts_advance gives done=1. Asserting reset mid-INIT clears rd_valid immediately and restores IDLE.
